// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight and
// buffers returned {instr, pc} pairs in a small FIFO for the instruction queue.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        deq,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   target, target_next;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  // Flush wins over both ends of the FIFO in the same cycle.
  assign push       = (state == S_WAIT) && instr_mem_resp && !flush;
  assign pop        = deq && valid_o && !flush;
  assign count_next = count + CW'(push) - CW'(pop);

  assign instr_read        = (state == S_WAIT) || (state == S_DROP);
  assign instr_mem_address = pc;
  assign valid_o           = (count != '0);
  assign instr_o           = buf_instr[head];
  assign pc_o              = buf_pc[head];

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    target_next = target;
    unique case (state)
      S_IDLE: begin
        if (flush)              pc_next    = flush_pc;
        else if (count < FULL)  state_next = S_WAIT;
      end
      S_WAIT: begin
        if (instr_mem_resp) begin
          if (flush) begin
            pc_next    = flush_pc;
            state_next = S_IDLE;
          end else begin
            pc_next    = pc + 32'd4;
            state_next = (count_next < FULL) ? S_WAIT : S_IDLE;
          end
        end else if (flush) begin
          // The outstanding read cannot be cancelled; remember where to go.
          target_next = flush_pc;
          state_next  = S_DROP;
        end
      end
      S_DROP: begin
        if (instr_mem_resp) begin
          pc_next    = flush ? flush_pc : target;
          state_next = S_IDLE;
        end else if (flush) begin
          target_next = flush_pc;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      target <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      target <= target_next;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= count_next;
      end
    end
  end

  // NOTE: buffer storage is not reset; count gates valid_o, so stale
  // contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail] <= instr_mem_rdata;
      buf_pc[tail]    <= pc;
    end
  end

endmodule
